// File: rtl/dcache_pkg.sv
// Shared definitions for the direct-mapped write-back data cache:
// controller states, default geometry and per-line status flags.
package dcache_pkg;

    localparam int DATA_WIDTH      = 32;
    localparam int DEF_ADDR_BITS   = 32;
    localparam int DEF_INDEX_WIDTH = 3;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WB   = 2'd1,
        S_FILL = 2'd2,
        S_GAP  = 2'd3
    } state_t;

    typedef struct packed {
        logic valid;
        logic dirty;
    } line_flags_t;

    function automatic int tag_width(input int addr_bits, input int index_width);
        return addr_bits - index_width;
    endfunction

endpackage

// File: rtl/dcache_array.sv
// Line storage for the data cache: per-line valid/dirty flags, tag and data.
// Reads are combinational on idx; all updates happen at the clock edge.
module dcache_array
    import dcache_pkg::*;
#(
    parameter int INDEX_WIDTH = DEF_INDEX_WIDTH,
    parameter int TAG_WIDTH   = tag_width(DEF_ADDR_BITS, DEF_INDEX_WIDTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [INDEX_WIDTH-1:0] idx,
    output logic                  rd_valid,
    output logic                  rd_dirty,
    output logic [TAG_WIDTH-1:0]  rd_tag,
    output logic [DATA_WIDTH-1:0] rd_data,
    input  logic                  line_we,
    input  logic                  line_dirty,
    input  logic [TAG_WIDTH-1:0]  wr_tag,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  dirty_clr
);

    localparam int LINES = 1 << INDEX_WIDTH;

    line_flags_t [LINES-1:0] flags;
    logic [TAG_WIDTH-1:0]    tags [LINES];
    logic [DATA_WIDTH-1:0]   data [LINES];

    assign rd_valid = flags[idx].valid;
    assign rd_dirty = flags[idx].dirty;
    assign rd_tag   = tags[idx];
    assign rd_data  = data[idx];

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            flags <= '0;
        end else if (line_we) begin
            flags[idx] <= '{valid: 1'b1, dirty: line_dirty};
        end else if (dirty_clr) begin
            flags[idx].dirty <= 1'b0;
        end
    end

    // NOTE: tag/data arrays have no reset; valid gates their use, and this keeps them plain RAM.
    always_ff @(posedge clk) begin
        if (line_we) begin
            tags[idx] <= wr_tag;
            data[idx] <= wr_data;
        end
    end

endmodule

// File: rtl/dcache_ctrl.sv
// Direct-mapped write-back, write-allocate data cache controller. Hits finish
// in the same cycle; misses stall while a write-back and/or fill runs on RAM.
module dcache_ctrl
    import dcache_pkg::*;
#(
    parameter int INDEX_WIDTH = DEF_INDEX_WIDTH,
    parameter int ADDR_BITS   = DEF_ADDR_BITS
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_BITS-1:0]  cpu_addr,
    input  logic                  cpu_ren,
    input  logic                  cpu_wen,
    input  logic [DATA_WIDTH-1:0] cpu_din,
    output logic [DATA_WIDTH-1:0] cpu_dout,
    output logic                  cpu_stall,
    output logic [ADDR_BITS-1:0]  mem_addr,
    output logic                  mem_ren,
    output logic                  mem_wen,
    output logic [DATA_WIDTH-1:0] mem_dout,
    input  logic [DATA_WIDTH-1:0] mem_din,
    input  logic                  mem_ack
);

    localparam int TAG_WIDTH = tag_width(ADDR_BITS, INDEX_WIDTH);

    state_t                  state, next_state;
    logic [INDEX_WIDTH-1:0]  idx;
    logic [TAG_WIDTH-1:0]    cpu_tag;
    logic                    rd_valid, rd_dirty;
    logic [TAG_WIDTH-1:0]    rd_tag;
    logic [DATA_WIDTH-1:0]   rd_data;
    logic                    hit, victim_dirty, access, clean_write_miss;
    logic                    line_we, line_dirty, dirty_clr;
    logic [DATA_WIDTH-1:0]   line_data;

    assign idx              = cpu_addr[INDEX_WIDTH-1:0];
    assign cpu_tag          = cpu_addr[ADDR_BITS-1:INDEX_WIDTH];
    assign hit              = rd_valid && (rd_tag == cpu_tag);
    assign victim_dirty     = rd_valid && rd_dirty;
    assign access           = cpu_ren || cpu_wen;
    // One-word lines: a store miss over a clean victim just overwrites it.
    assign clean_write_miss = cpu_wen && !hit && !victim_dirty;

    dcache_array #(
        .INDEX_WIDTH (INDEX_WIDTH),
        .TAG_WIDTH   (TAG_WIDTH)
    ) u_array (
        .clk        (clk),
        .rst        (rst),
        .idx        (idx),
        .rd_valid   (rd_valid),
        .rd_dirty   (rd_dirty),
        .rd_tag     (rd_tag),
        .rd_data    (rd_data),
        .line_we    (line_we),
        .line_dirty (line_dirty),
        .wr_tag     (cpu_tag),
        .wr_data    (line_data),
        .dirty_clr  (dirty_clr)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= next_state;
    end

    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    always_comb begin
        next_state = state;
        case (state)
            S_IDLE: begin
                if (access && !hit) begin
                    if (victim_dirty)  next_state = S_WB;
                    else if (!cpu_wen) next_state = S_FILL;
                end
            end
            S_WB:    if (mem_ack) next_state = S_GAP;
            S_FILL:  if (mem_ack) next_state = S_GAP;
            default: next_state = S_IDLE;
        endcase
    end

    always_comb begin
        cpu_stall  = (state != S_IDLE) || (access && !hit && !clean_write_miss);
        cpu_dout   = '0;
        line_we    = 1'b0;
        line_dirty = 1'b0;
        line_data  = cpu_din;
        dirty_clr  = 1'b0;
        case (state)
            S_IDLE: begin
                if (cpu_ren && !cpu_wen && hit) cpu_dout = rd_data;
                if (cpu_wen && (hit || !victim_dirty)) begin
                    line_we    = 1'b1;
                    line_dirty = 1'b1;
                end
            end
            S_WB:   dirty_clr = mem_ack;
            S_FILL: begin
                if (mem_ack) begin
                    line_we   = 1'b1;
                    line_data = mem_din;
                end
            end
            default: ;
        endcase
    end

    // Requests are raised only on leaving IDLE and dropped on ack, so the
    // address and write data stay frozen for the whole handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_ren  <= 1'b0;
            mem_wen  <= 1'b0;
            mem_addr <= '0;
            mem_dout <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (next_state == S_WB) begin
                        mem_wen  <= 1'b1;
                        mem_addr <= {rd_tag, idx};
                        mem_dout <= rd_data;
                    end else if (next_state == S_FILL) begin
                        mem_ren  <= 1'b1;
                        mem_addr <= cpu_addr;
                    end
                end
                S_WB, S_FILL: begin
                    if (mem_ack) begin
                        mem_ren <= 1'b0;
                        mem_wen <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_dcache_ctrl.sv
// Scoreboard bench for dcache_ctrl against a multi-cycle RAM model: expected CPU
// completions and RAM requests are queued by the stimulus and checked by monitors.
module tb_dcache_ctrl;

    localparam int DELAY = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] cpu_addr, cpu_din, cpu_dout;
    logic        cpu_ren, cpu_wen, cpu_stall;
    logic [31:0] mem_addr, mem_dout;
    logic [31:0] mem_din = '0;
    logic        mem_ren, mem_wen;
    logic        mem_ack = 1'b0;
    logic        ram_load;

    always #5 clk = ~clk;

    dcache_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .cpu_addr  (cpu_addr),
        .cpu_ren   (cpu_ren),
        .cpu_wen   (cpu_wen),
        .cpu_din   (cpu_din),
        .cpu_dout  (cpu_dout),
        .cpu_stall (cpu_stall),
        .mem_addr  (mem_addr),
        .mem_ren   (mem_ren),
        .mem_wen   (mem_wen),
        .mem_dout  (mem_dout),
        .mem_din   (mem_din),
        .mem_ack   (mem_ack)
    );

    typedef struct {
        bit          is_read;
        logic [31:0] data;
        int          stall;
        string       name;
    } cpu_exp_t;

    typedef struct {
        bit          wen;
        logic [31:0] addr;
        logic [31:0] data;
    } mem_exp_t;

    cpu_exp_t cpu_q[$];
    mem_exp_t mem_q[$];
    int n_checks = 0;
    int n_fail   = 0;

    // RAM model: ack arrives in the DELAY-th cycle a request is held high.
    logic [31:0] ram [256];
    int ram_cnt = 0;

    always @(posedge clk) begin
        mem_ack <= 1'b0;
        if (ram_load) begin
            for (int k = 0; k < 256; k++) ram[k] <= 32'h1000 + 32'(k);
            ram_cnt <= 0;
        end else if ((mem_ren || mem_wen) && !mem_ack && mem_addr < 256) begin
            if (ram_cnt == DELAY - 2) begin
                mem_ack <= 1'b1;
                ram_cnt <= 0;
                if (mem_wen) ram[mem_addr[7:0]] <= mem_dout;
                else         mem_din <= ram[mem_addr[7:0]];
            end else begin
                ram_cnt <= ram_cnt + 1;
            end
        end else begin
            ram_cnt <= 0;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual 0x%08h required 0x%08h", name, act, exp);
        end
    endtask

    task automatic expect_mem(input bit wen, input logic [31:0] addr, input logic [31:0] data);
        mem_exp_t m;
        m.wen  = wen;
        m.addr = addr;
        m.data = data;
        mem_q.push_back(m);
    endtask

    task automatic access(input bit ren, input bit wen, input logic [31:0] addr,
                          input logic [31:0] din, input bit is_read,
                          input logic [31:0] exp_data, input int exp_stall, input string name);
        cpu_exp_t e;
        bit done;
        e.is_read = is_read;
        e.data    = exp_data;
        e.stall   = exp_stall;
        e.name    = name;
        cpu_q.push_back(e);
        @(posedge clk);
        #1;
        cpu_ren  = ren;
        cpu_wen  = wen;
        cpu_addr = addr;
        cpu_din  = din;
        done = 1'b0;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clk);
            if (!cpu_stall) done = 1'b1;
        end
        check({name, "_done"}, 32'(done), 32'd1);
        @(posedge clk);
        #1;
        cpu_ren = 1'b0;
        cpu_wen = 1'b0;
    endtask

    task automatic apply_reset();
        @(posedge clk);
        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    // CPU-side monitor: counts stall cycles and checks each completed access.
    initial begin
        int stall_cnt;
        cpu_exp_t e;
        stall_cnt = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                stall_cnt = 0;
            end else if (cpu_ren || cpu_wen) begin
                if (cpu_stall) begin
                    stall_cnt++;
                end else begin
                    if (cpu_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected_completion: addr 0x%08h, none expected", cpu_addr);
                    end else begin
                        e = cpu_q.pop_front();
                        check({e.name, "_stall"}, 32'(stall_cnt), 32'(e.stall));
                        if (e.is_read) check({e.name, "_data"}, cpu_dout, e.data);
                    end
                    stall_cnt = 0;
                end
            end
        end
    end

    // RAM-side monitor: request scoreboard plus handshake protocol rules.
    initial begin
        logic        prev_req, prev_ack, req;
        logic [31:0] prev_addr, prev_dout;
        mem_exp_t    m;
        prev_req = 1'b0;
        prev_ack = 1'b0;
        prev_addr = '0;
        prev_dout = '0;
        forever begin
            @(negedge clk);
            req = mem_ren || mem_wen;
            if (rst) begin
                prev_req = 1'b0;
                prev_ack = 1'b0;
            end else begin
                if (req) check("proto_exclusive", 32'(mem_ren && mem_wen), 32'd0);
                if (prev_ack) begin
                    check("proto_gap", 32'(req), 32'd0);
                end else if (prev_req && req) begin
                    check("proto_addr_stable", mem_addr, prev_addr);
                    if (mem_wen) check("proto_dout_stable", mem_dout, prev_dout);
                end
                if (req && !prev_req) begin
                    if (mem_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected_mem_req: addr 0x%08h wen %0d, none expected",
                                 mem_addr, mem_wen);
                    end else begin
                        m = mem_q.pop_front();
                        check("mem_req_wen", 32'(mem_wen), 32'(m.wen));
                        check("mem_req_addr", mem_addr, m.addr);
                        if (m.wen) check("mem_req_data", mem_dout, m.data);
                    end
                end
                prev_req  = req;
                prev_ack  = mem_ack;
                prev_addr = mem_addr;
                prev_dout = mem_dout;
            end
        end
    end

    initial begin
        rst      = 1'b1;
        ram_load = 1'b1;
        cpu_ren  = 1'b0;
        cpu_wen  = 1'b0;
        cpu_addr = '0;
        cpu_din  = '0;
        repeat (2) @(posedge clk);
        #1;
        rst      = 1'b0;
        ram_load = 1'b0;

        @(negedge clk);
        check("reset_mem_ren", 32'(mem_ren), 32'd0);
        check("reset_mem_wen", 32'(mem_wen), 32'd0);
        check("reset_mem_addr", mem_addr, 32'd0);
        check("reset_mem_dout", mem_dout, 32'd0);
        check("reset_cpu_stall", 32'(cpu_stall), 32'd0);
        check("reset_cpu_dout", cpu_dout, 32'd0);

        // Clean read miss, then hit on the same line.
        expect_mem(1'b0, 32'h03, 32'h0);
        access(1'b1, 1'b0, 32'h03, 32'h0, 1'b1, 32'h1003, DELAY + 2, "t1_read_miss");
        access(1'b1, 1'b0, 32'h03, 32'h0, 1'b1, 32'h1003, 0, "t1_read_hit");

        // Write miss over an invalid line installs without RAM traffic.
        apply_reset();
        access(1'b0, 1'b1, 32'h05, 32'hDEADBEEF, 1'b0, 32'h0, 0, "t2_write_miss");
        access(1'b1, 1'b0, 32'h05, 32'h0, 1'b1, 32'hDEADBEEF, 0, "t2_read_hit");
        check("t2_ram5_untouched", ram[5], 32'h1005);

        // Read miss over a dirty victim: write-back, gap, fill.
        expect_mem(1'b1, 32'h05, 32'hDEADBEEF);
        expect_mem(1'b0, 32'h0D, 32'h0);
        access(1'b1, 1'b0, 32'h0D, 32'h0, 1'b1, 32'h100D, 2 * DELAY + 4, "t3_dirty_read_miss");
        check("t3_ram5_written", ram[5], 32'hDEADBEEF);

        // Simultaneous read and write acts as a store.
        access(1'b1, 1'b1, 32'h02, 32'h55, 1'b0, 32'h0, 0, "t4_ren_wen");
        access(1'b1, 1'b0, 32'h02, 32'h0, 1'b1, 32'h55, 0, "t4_read_back");

        // Write miss over a dirty victim: write-back only, then install.
        expect_mem(1'b1, 32'h02, 32'h55);
        access(1'b0, 1'b1, 32'h0A, 32'h77, 1'b0, 32'h0, DELAY + 2, "t4_dirty_write_miss");
        access(1'b1, 1'b0, 32'h0A, 32'h0, 1'b1, 32'h77, 0, "t4_read_0a");
        check("t4_ram2_written", ram[2], 32'h55);

        // Reset during a fill aborts it; the line is refetched afterwards.
        apply_reset();
        expect_mem(1'b0, 32'h07, 32'h0);
        @(posedge clk);
        #1;
        cpu_ren  = 1'b1;
        cpu_addr = 32'h07;
        repeat (3) @(posedge clk);
        #1;
        rst     = 1'b1;
        cpu_ren = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("t5_abort_mem_ren", 32'(mem_ren), 32'd0);
        check("t5_abort_stall", 32'(cpu_stall), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        expect_mem(1'b0, 32'h07, 32'h0);
        access(1'b1, 1'b0, 32'h07, 32'h0, 1'b1, 32'h1007, DELAY + 2, "t5_refetch");

        repeat (3) @(posedge clk);
        check("cpu_queue_drained", 32'(cpu_q.size()), 32'd0);
        check("mem_queue_drained", 32'(mem_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
